// File: rtl/mips_run_ctrl_if.sv
// Control/status bundle between the run controller and its host.
// The slave side is the controller; the master side is the host/bench.
interface mips_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  pc_i;
  logic             pc_valid_i;
  logic             core_reset_o;
  logic             core_en_o;
  logic             running_o;
  logic             done_o;
  logic             halted_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_count_o;

  modport slave (
    input  start, pc_i, pc_valid_i,
    output core_reset_o, core_en_o, running_o, done_o,
           halted_o, timeout_o, cycle_count_o
  );

  modport master (
    output start, pc_i, pc_valid_i,
    input  core_reset_o, core_en_o, running_o, done_o,
           halted_o, timeout_o, cycle_count_o
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: reset sequencing, cycle budget,
// halt detection (explicit halt PC or a PC stuck for HALT_REPEAT valid cycles).
module mips_run_ctrl #(
  parameter int              RESET_CYCLES = 2,
  parameter int              MAX_CYCLES   = 9,
  parameter int              CNT_W        = 16,
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] HALT_PC      = PC_W'(32'hFFFF_FFFC),
  parameter int              HALT_REPEAT  = 3
) (
  input logic            clk,
  input logic            reset,
  mips_run_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RSEQ, S_RUN, S_DONE} state_t;

  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int ST_W = $clog2(HALT_REPEAT + 1);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(HALT_REPEAT - 1);

  state_t           r_state, w_next;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [PC_W-1:0]  r_last_pc;
  logic             r_last_vld;
  logic [ST_W-1:0]  r_stable_cnt;
  logic             r_halted;
  logic             r_timeout;

  logic w_start, w_pc_same, w_halt, w_tmo;

  assign w_start   = bus.start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_pc_same = r_last_vld && (bus.pc_i == r_last_pc);
  assign w_halt    = bus.pc_valid_i &&
                     (bus.pc_i == HALT_PC || (w_pc_same && r_stable_cnt == ST_LAST));
  assign w_tmo     = (r_cycle_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_RSEQ;
      S_RSEQ:  if (r_rst_cnt == RC_W'(1)) w_next = S_RUN;
      S_RUN:   if (w_halt || w_tmo) w_next = S_DONE;
      S_DONE:  if (w_start) w_next = S_RSEQ;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_cnt    <= '0;
      r_cycle_cnt  <= '0;
      r_last_pc    <= '0;
      r_last_vld   <= 1'b0;
      r_stable_cnt <= '0;
      r_halted     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_rst_cnt   <= RC_LOAD;
            r_cycle_cnt <= '0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
        S_RSEQ: begin
          r_rst_cnt    <= r_rst_cnt - RC_W'(1);
          r_last_vld   <= 1'b0;
          r_stable_cnt <= '0;
        end
        S_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          // Invalid PC cycles neither extend nor break a stable-PC streak.
          if (bus.pc_valid_i) begin
            r_stable_cnt <= w_pc_same ? r_stable_cnt + ST_W'(1) : '0;
            r_last_pc    <= bus.pc_i;
            r_last_vld   <= 1'b1;
          end
          if (w_halt)     r_halted  <= 1'b1;
          else if (w_tmo) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Core stays out of reset in DONE so its state can be inspected.
  assign bus.core_reset_o  = (r_state == S_IDLE) || (r_state == S_RSEQ);
  assign bus.core_en_o     = (r_state == S_RUN);
  assign bus.running_o     = (r_state == S_RUN);
  assign bus.done_o        = (r_state == S_DONE);
  assign bus.halted_o      = r_halted;
  assign bus.timeout_o     = r_timeout;
  assign bus.cycle_count_o = r_cycle_cnt;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with default parameters.
module tb_mips_run_ctrl;
  localparam logic [31:0] HALT_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mips_run_ctrl_if #(.PC_W(32), .CNT_W(16)) u_if ();

  mips_run_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_end(input string tag, input logic h, input logic t, input int cnt);
    chk({tag, "_done"},  32'(u_if.done_o), 32'd1);
    chk({tag, "_en"},    32'(u_if.core_en_o), 32'd0);
    chk({tag, "_crst"},  32'(u_if.core_reset_o), 32'd0);
    chk({tag, "_halt"},  32'(u_if.halted_o), 32'(h));
    chk({tag, "_tmo"},   32'(u_if.timeout_o), 32'(t));
    chk({tag, "_count"}, 32'(u_if.cycle_count_o), 32'(cnt));
  endtask

  // Pulses start, walks the reset sequence and leaves the bench in the first
  // RUN cycle; poke raises start during RSEQ, which must be ignored.
  task automatic begin_run(input string tag, input bit poke);
    u_if.start = 1'b1;
    tick();
    u_if.start = poke;
    chk({tag, "_rseq_crst"}, 32'(u_if.core_reset_o), 32'd1);
    chk({tag, "_clr_halt"},  32'(u_if.halted_o), 32'd0);
    chk({tag, "_clr_tmo"},   32'(u_if.timeout_o), 32'd0);
    chk({tag, "_clr_cnt"},   32'(u_if.cycle_count_o), 32'd0);
    tick();
    u_if.start = 1'b0;
    chk({tag, "_rseq2_crst"}, 32'(u_if.core_reset_o), 32'd1);
    chk({tag, "_rseq2_run"},  32'(u_if.running_o), 32'd0);
    tick();
    chk({tag, "_run_entry"}, 32'(u_if.running_o), 32'd1);
    chk({tag, "_run_crst"},  32'(u_if.core_reset_o), 32'd0);
    chk({tag, "_run_en"},    32'(u_if.core_en_o), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs[6];
    logic        vls[6];

    reset = 1'b1;
    u_if.start = 1'b0;
    u_if.pc_i = '0;
    u_if.pc_valid_i = 1'b1;
    repeat (3) tick();
    chk("rst_crst",    32'(u_if.core_reset_o), 32'd1);
    chk("rst_en",      32'(u_if.core_en_o), 32'd0);
    chk("rst_running", 32'(u_if.running_o), 32'd0);
    chk("rst_done",    32'(u_if.done_o), 32'd0);
    chk("rst_flags",   32'({u_if.halted_o, u_if.timeout_o}), 32'd0);
    chk("rst_count",   32'(u_if.cycle_count_o), 32'd0);
    @(negedge clk) reset = 1'b0;
    tick();
    chk("idle_crst", 32'(u_if.core_reset_o), 32'd1);

    // Timeout run with PC +4 per cycle; stray start in RSEQ and RUN.
    begin_run("t1", 1'b1);
    for (int i = 0; i < 9; i++) begin
      chk("t1_running", 32'(u_if.running_o), 32'd1);
      chk("t1_cnt", 32'(u_if.cycle_count_o), 32'(i));
      u_if.start = (i == 3);
      u_if.pc_i = 32'(4 * i);
      tick();
    end
    u_if.start = 1'b0;
    chk_end("t1", 1'b0, 1'b1, 9);
    tick();
    chk_end("t1_hold", 1'b0, 1'b1, 9);

    // Stuck PC: 0,4,8,8,8,8 halts after the fourth 8.
    pcs = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8, 32'd8};
    begin_run("t2", 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_running", 32'(u_if.running_o), 32'd1);
      u_if.pc_i = pcs[i];
      tick();
    end
    chk_end("t2", 1'b1, 1'b0, 6);

    // Explicit halt PC on the first RUN cycle.
    begin_run("t3", 1'b0);
    u_if.pc_i = HALT_PC;
    tick();
    chk_end("t3", 1'b1, 1'b0, 1);

    // Halt PC on the last budgeted cycle: halt wins over timeout.
    begin_run("t4", 1'b0);
    for (int i = 0; i < 9; i++) begin
      u_if.pc_i = (i == 8) ? HALT_PC : 32'(16 + 4 * i);
      tick();
    end
    chk_end("t4", 1'b1, 1'b0, 9);

    // Invalid cycles hold the stable-PC streak.
    pcs = '{32'd8, 32'd0, 32'd8, 32'd0, 32'd8, 32'd8};
    vls = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    begin_run("t5", 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_running", 32'(u_if.running_o), 32'd1);
      u_if.pc_i = pcs[i];
      u_if.pc_valid_i = vls[i];
      tick();
    end
    u_if.pc_valid_i = 1'b1;
    chk_end("t5", 1'b1, 1'b0, 6);

    // Asynchronous reset mid-run at count 4, then a clean timeout run.
    begin_run("t6", 1'b0);
    for (int i = 0; i < 4; i++) begin
      u_if.pc_i = 32'(4 * i);
      tick();
    end
    chk("t6_cnt4", 32'(u_if.cycle_count_o), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("t6_crst",    32'(u_if.core_reset_o), 32'd1);
    chk("t6_en",      32'(u_if.core_en_o), 32'd0);
    chk("t6_running", 32'(u_if.running_o), 32'd0);
    chk("t6_done",    32'(u_if.done_o), 32'd0);
    chk("t6_flags",   32'({u_if.halted_o, u_if.timeout_o}), 32'd0);
    chk("t6_count",   32'(u_if.cycle_count_o), 32'd0);
    @(negedge clk) reset = 1'b0;
    begin_run("t7", 1'b0);
    for (int i = 0; i < 9; i++) begin
      u_if.pc_i = 32'(100 + 4 * i);
      tick();
    end
    chk_end("t7", 1'b0, 1'b1, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
